// File: rtl/multi_lane_sum_pkg.sv
// Shared opcodes, controller state encoding and saturation limits for the
// multi-lane sum controller.
package multi_lane_sum_pkg;

  localparam logic [1:0] OP_CLEAR   = 2'd0;
  localparam logic [1:0] OP_GO      = 2'd1;
  localparam logic [1:0] OP_READ    = 2'd2;
  localparam logic [1:0] OP_GO_READ = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Two's-complement extreme of a width-bit signed value, returned in 64 bits;
  // callers keep the low width bits (width must be 2..64).
  function automatic logic [63:0] sat_limit(input int width, input logic neg);
    logic [63:0] max_v;
    max_v = (64'd1 << (width - 1)) - 64'd1;
    return neg ? ~max_v : max_v;
  endfunction

endpackage

// File: rtl/multi_lane_sum_ctrl_lane_select.sv
// Lowest-set-bit priority encoder over the lanes still waiting to be issued.
module lane_select #(
  parameter int N_LANES = 3,
  parameter int IDX_W   = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic [N_LANES-1:0] mask,
  output logic [IDX_W-1:0]   idx,
  output logic               any_left
);

  always_comb begin
    idx      = '0;
    any_left = |mask;
    // Walk downward so the lowest set bit is the last one written.
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (mask[i]) idx = i[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/multi_lane_sum_ctrl.sv
// Issues masked operands to an external pipelined evaluator one at a time and
// accumulates the returned signed results into a saturating accumulator.
module multi_lane_sum_ctrl
  import multi_lane_sum_pkg::*;
#(
  parameter int N_LANES    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int EVAL_WIDTH = 22,
  parameter int ACC_WIDTH  = 32,
  parameter int N_WIDTH    = 2,
  parameter int CNT_WIDTH  = $clog2(N_LANES + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_en,
  input  logic                          start,
  input  logic [N_WIDTH-1:0]            n,
  input  logic [N_LANES-1:0]            lane_mask,
  input  logic [N_LANES*DATA_WIDTH-1:0] x_in,
  output logic                          ev_start,
  output logic [DATA_WIDTH-1:0]         ev_x,
  input  logic                          ev_ready,
  input  logic                          ev_done,
  input  logic [EVAL_WIDTH-1:0]         ev_y,
  output logic [ACC_WIDTH-1:0]          result,
  output logic                          overflow,
  output logic                          busy,
  output logic                          done
);

  localparam int IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  localparam logic [63:0] ACC_MAX64 = sat_limit(ACC_WIDTH, 1'b0);
  localparam logic [63:0] ACC_MIN64 = sat_limit(ACC_WIDTH, 1'b1);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_MAX64[ACC_WIDTH-1:0];
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_MIN64[ACC_WIDTH-1:0];

  // Returns {saturated, value}: one guard bit catches overflow of the
  // sign-extended sum, which is then pinned to the matching extreme.
  function automatic logic [ACC_WIDTH:0] sat_add(
    input logic signed [ACC_WIDTH-1:0]  a,
    input logic signed [EVAL_WIDTH-1:0] b
  );
    logic signed [ACC_WIDTH:0] s;
    s = (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(b);
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      return {1'b1, (s[ACC_WIDTH] ? ACC_MIN : ACC_MAX)};
    return {1'b0, s[ACC_WIDTH-1:0]};
  endfunction

  state_t                         state, state_nxt;
  logic signed [ACC_WIDTH-1:0]    acc, acc_nxt;
  logic signed [ACC_WIDTH-1:0]    result_r, result_nxt;
  logic                           ovf_r, ovf_nxt;
  logic [CNT_WIDTH-1:0]           issued, issued_nxt;
  logic [CNT_WIDTH-1:0]           returned, returned_nxt;
  logic [N_LANES-1:0]             rem_mask, rem_nxt;
  logic [N_LANES*DATA_WIDTH-1:0]  x_reg, x_nxt;
  logic                           go_read, go_read_nxt;

  logic [IDX_W-1:0]               sel_idx;
  logic                           any_left;
  logic                           transfer;
  logic                           ev_ok;
  logic [ACC_WIDTH:0]             sum;

  lane_select #(
    .N_LANES (N_LANES),
    .IDX_W   (IDX_W)
  ) u_lane_select (
    .mask     (rem_mask),
    .idx      (sel_idx),
    .any_left (any_left)
  );

  assign ev_start = (state == S_ISSUE) && any_left;
  assign ev_x     = x_reg[sel_idx*DATA_WIDTH +: DATA_WIDTH];
  assign transfer = ev_start && ev_ready;
  assign ev_ok    = ev_done && ((state == S_ISSUE) || (state == S_DRAIN));
  assign sum      = sat_add(acc, ev_y);

  assign result   = result_r;
  assign overflow = ovf_r;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    result_nxt   = result_r;
    ovf_nxt      = ovf_r;
    issued_nxt   = issued;
    returned_nxt = returned;
    rem_nxt      = rem_mask;
    x_nxt        = x_reg;
    go_read_nxt  = go_read;

    if (ev_ok) begin
      acc_nxt      = sum[ACC_WIDTH-1:0];
      ovf_nxt      = ovf_r | sum[ACC_WIDTH];
      returned_nxt = returned + CNT_WIDTH'(1);
    end

    if (transfer) begin
      rem_nxt    = rem_mask & ~(N_LANES'(1) << sel_idx);
      issued_nxt = issued + CNT_WIDTH'(1);
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          case (n)
            N_WIDTH'(OP_CLEAR): begin
              acc_nxt   = '0;
              ovf_nxt   = 1'b0;
              state_nxt = S_DONE;
            end
            N_WIDTH'(OP_READ): begin
              result_nxt = acc;
              state_nxt  = S_DONE;
            end
            N_WIDTH'(OP_GO), N_WIDTH'(OP_GO_READ): begin
              x_nxt        = x_in;
              rem_nxt      = lane_mask;
              issued_nxt   = '0;
              returned_nxt = '0;
              go_read_nxt  = (n == N_WIDTH'(OP_GO_READ));
              if (lane_mask == '0) begin
                if (n == N_WIDTH'(OP_GO_READ)) result_nxt = acc;
                state_nxt = S_DONE;
              end else begin
                state_nxt = S_ISSUE;
              end
            end
            default: state_nxt = S_IDLE;
          endcase
        end
      end
      S_ISSUE: begin
        // Exit test uses the updated counts so a coincident return is seen.
        if (transfer && (rem_nxt == '0)) begin
          if (returned_nxt == issued_nxt) begin
            if (go_read) result_nxt = acc_nxt;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (returned_nxt == issued_nxt) begin
          if (go_read) result_nxt = acc_nxt;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      acc      <= '0;
      result_r <= '0;
      ovf_r    <= 1'b0;
      issued   <= '0;
      returned <= '0;
      rem_mask <= '0;
      x_reg    <= '0;
      go_read  <= 1'b0;
    end else if (clk_en) begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      result_r <= result_nxt;
      ovf_r    <= ovf_nxt;
      issued   <= issued_nxt;
      returned <= returned_nxt;
      rem_mask <= rem_nxt;
      x_reg    <= x_nxt;
      go_read  <= go_read_nxt;
    end
  end

endmodule

// File: tb/tb_multi_lane_sum_ctrl.sv
// Directed bench for multi_lane_sum_ctrl with a latency-3 evaluator model.
module tb_multi_lane_sum_ctrl;
  import multi_lane_sum_pkg::*;

  localparam int NL = 3;
  localparam int DW = 32;
  localparam int EW = 22;
  localparam int AW = 22;
  localparam int NW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              clk_en;
  logic              start;
  logic [NW-1:0]     n;
  logic [NL-1:0]     lane_mask;
  logic [NL*DW-1:0]  x_in;
  logic              ev_start;
  logic [DW-1:0]     ev_x;
  logic              ev_ready;
  logic              ev_done;
  logic [EW-1:0]     ev_y;
  logic [AW-1:0]     result;
  logic              overflow;
  logic              busy;
  logic              done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multi_lane_sum_ctrl #(
    .N_LANES    (NL),
    .DATA_WIDTH (DW),
    .EVAL_WIDTH (EW),
    .ACC_WIDTH  (AW),
    .N_WIDTH    (NW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_en    (clk_en),
    .start     (start),
    .n         (n),
    .lane_mask (lane_mask),
    .x_in      (x_in),
    .ev_start  (ev_start),
    .ev_x      (ev_x),
    .ev_ready  (ev_ready),
    .ev_done   (ev_done),
    .ev_y      (ev_y),
    .result    (result),
    .overflow  (overflow),
    .busy      (busy),
    .done      (done)
  );

  // Evaluator model: y = x[21:0], three enabled edges from accept to consume.
  logic [2:0]    ev_vld;
  logic [EW-1:0] ev_d0, ev_d1, ev_d2;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_vld <= '0;
      ev_d0  <= '0;
      ev_d1  <= '0;
      ev_d2  <= '0;
    end else if (clk_en) begin
      ev_vld <= {ev_vld[1:0], ev_start & ev_ready};
      ev_d0  <= ev_x[EW-1:0];
      ev_d1  <= ev_d0;
      ev_d2  <= ev_d1;
    end
  end
  assign ev_done = ev_vld[2];
  assign ev_y    = ev_d2;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && clk_en && ev_done && (!busy || done))
      check_val("ev_done_outside_active", 64'(busy & ~done), 64'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [2:0] mask, input logic [95:0] x);
    start     = 1'b1;
    n         = op;
    lane_mask = mask;
    x_in      = x;
    tick();
    start     = 1'b0;
  endtask

  task automatic simple_op(input string tag, input logic [1:0] op);
    cmd(op, 3'b000, '0);
    check_val({tag, "_done_t1"}, 64'(done), 64'd1);
    check_val({tag, "_busy_t1"}, 64'(busy), 64'd1);
    tick();
    check_val({tag, "_done_t2"}, 64'(done), 64'd0);
    check_val({tag, "_busy_t2"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k;
    k = 0;
    while (done !== 1'b1 && k < limit) begin
      tick();
      k++;
    end
    check_val({tag, "_done_seen"}, 64'(done), 64'd1);
  endtask

  initial begin
    rst       = 1'b1;
    clk_en    = 1'b1;
    start     = 1'b0;
    n         = '0;
    lane_mask = '0;
    x_in      = '0;
    ev_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_result",   64'(result),   64'd0);
    check_val("rst_overflow", 64'(overflow), 64'd0);
    check_val("rst_busy",     64'(busy),     64'd0);
    check_val("rst_done",     64'(done),     64'd0);
    check_val("rst_ev_start", 64'(ev_start), 64'd0);
    rst = 1'b0;
    tick();

    simple_op("clear0", OP_CLEAR);
    check_val("clear0_ovf", 64'(overflow), 64'd0);
    simple_op("read0", OP_READ);
    check_val("read0_result", 64'(result), 64'd0);

    // All three lanes back to back.
    cmd(OP_GO_READ, 3'b111, {32'd30, 32'd20, 32'd10});
    check_val("go3_x0", 64'(ev_x), 64'd10);
    check_val("go3_s0", 64'(ev_start), 64'd1);
    tick();
    check_val("go3_x1", 64'(ev_x), 64'd20);
    tick();
    check_val("go3_x2", 64'(ev_x), 64'd30);
    tick();
    check_val("go3_s_off", 64'(ev_start), 64'd0);
    check_val("go3_drain_busy", 64'(busy), 64'd1);
    wait_done("go3", 20);
    check_val("go3_result", 64'(result), 64'd60);
    tick();
    check_val("go3_done_pulse", 64'(done), 64'd0);

    // Lane 1 masked out: only lanes 0 and 2 are issued.
    cmd(OP_GO_READ, 3'b101, {32'd7, 32'd99, 32'd5});
    check_val("m101_x0", 64'(ev_x), 64'd5);
    tick();
    check_val("m101_x2", 64'(ev_x), 64'd7);
    check_val("m101_s1", 64'(ev_start), 64'd1);
    tick();
    check_val("m101_s_off", 64'(ev_start), 64'd0);
    wait_done("m101", 20);
    check_val("m101_result", 64'(result), 64'd72);
    tick();

    // GO without read keeps result until an explicit READ.
    cmd(OP_GO, 3'b111, {32'd1, 32'd2, 32'd3});
    wait_done("go_only", 20);
    check_val("go_only_result", 64'(result), 64'd72);
    tick();
    simple_op("read1", OP_READ);
    check_val("read1_result", 64'(result), 64'd78);

    // Ready stall then clock-enable stall in the middle of ISSUE.
    cmd(OP_GO_READ, 3'b111, {32'd300, 32'd200, 32'd100});
    check_val("stall_x0", 64'(ev_x), 64'd100);
    tick();
    check_val("stall_x1", 64'(ev_x), 64'd200);
    ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val("stall_rdy_x", 64'(ev_x), 64'd200);
      check_val("stall_rdy_s", 64'(ev_start), 64'd1);
    end
    clk_en   = 1'b0;
    ev_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("stall_en_x", 64'(ev_x), 64'd200);
      check_val("stall_en_s", 64'(ev_start), 64'd1);
    end
    clk_en = 1'b1;
    tick();
    check_val("stall_x2", 64'(ev_x), 64'd300);
    wait_done("stall", 30);
    check_val("stall_result", 64'(result), 64'd678);
    tick();

    // Positive saturation.
    simple_op("clear1", OP_CLEAR);
    cmd(OP_GO_READ, 3'b111, {32'h001F_FFFF, 32'h001F_FFFF, 32'h001F_FFFF});
    wait_done("satp", 20);
    check_val("satp_result", 64'(result), 64'h1F_FFFF);
    check_val("satp_ovf", 64'(overflow), 64'd1);
    tick();
    simple_op("clear2", OP_CLEAR);
    check_val("clear2_ovf", 64'(overflow), 64'd0);
    simple_op("read2", OP_READ);
    check_val("read2_result", 64'(result), 64'd0);

    // Negative saturation.
    cmd(OP_GO_READ, 3'b111, {32'h0020_0000, 32'h0020_0000, 32'h0020_0000});
    wait_done("satn", 20);
    check_val("satn_result", 64'(result), 64'h20_0000);
    check_val("satn_ovf", 64'(overflow), 64'd1);
    tick();
    simple_op("clear3", OP_CLEAR);

    // Asynchronous reset while draining.
    cmd(OP_GO_READ, 3'b111, {32'd3, 32'd2, 32'd1});
    tick();
    tick();
    tick();
    check_val("drain_busy", 64'(busy), 64'd1);
    check_val("drain_s_off", 64'(ev_start), 64'd0);
    rst = 1'b1;
    #1;
    check_val("arst_result", 64'(result), 64'd0);
    check_val("arst_busy", 64'(busy), 64'd0);
    check_val("arst_done", 64'(done), 64'd0);
    check_val("arst_ovf", 64'(overflow), 64'd0);
    check_val("arst_ev_start", 64'(ev_start), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cmd(OP_GO, 3'b000, {32'd9, 32'd9, 32'd9});
    check_val("mask0_done_t1", 64'(done), 64'd1);
    tick();
    check_val("mask0_done_t2", 64'(done), 64'd0);
    simple_op("read3", OP_READ);
    check_val("read3_result", 64'(result), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_lane_sum_ctrl.md
Name: multi_lane_sum_ctrl

Overview:
Parametrised successor to the three-operand function-evaluation controller. It takes N_LANES operands and a lane mask, and sends each active operand in turn to an external pipelined evaluator (CORDIC/square/halve datapath) over a start/ready handshake. It accumulates the returned fixed-point results into a saturating signed accumulator. Opcodes CLEAR/GO/READ/GO_READ drive the block, which reports completion with a one-cycle done pulse.

Parameters:
N_LANES, 3, number of operand lanes (1..16)
DATA_WIDTH, 32, operand width
EVAL_WIDTH, 22, signed fixed-point evaluator result width
ACC_WIDTH, 32, signed accumulator/result width; must be >= EVAL_WIDTH
N_WIDTH, 2, opcode width
CNT_WIDTH, $clog2(N_LANES+1), derived, issue/return counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
clk_en  in  1  global enable; when low, all registers hold
start  in  1  command strobe, sampled in IDLE only
n  in  N_WIDTH  opcode: 0 CLEAR, 1 GO, 2 READ, 3 GO_READ
lane_mask  in  N_LANES  active lanes for GO/GO_READ
x_in  in  N_LANES*DATA_WIDTH  packed operands, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
ev_start  out  1  operand valid to evaluator
ev_x  out  DATA_WIDTH  operand to evaluator
ev_ready  in  1  evaluator accepts; transfer = ev_start & ev_ready
ev_done  in  1  evaluator result valid, one per accepted operand, in order
ev_y  in  EVAL_WIDTH  signed evaluator result
result  out  ACC_WIDTH  registered accumulator snapshot
overflow  out  1  sticky saturation flag
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, any state): state=IDLE; acc, result, counters, captured mask/operands = 0; done, ev_start, overflow = 0.
- The evaluator shares clk_en and rst. When clk_en=0, nothing changes and ev_done is ignored.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: with start & clk_en at edge T, decode n:
  - CLEAR: acc=0, overflow=0; go to DONE.
  - READ: result=acc; go to DONE.
  - GO/GO_READ: register x_in and lane_mask. If mask==0, go to DONE. Otherwise go to ISSUE.
- Latency from any transition to DONE: done=1 during cycle T+1 only. DONE always returns to IDLE on the next enabled edge.
- ISSUE:
  - ev_start=1; ev_x = lowest-index remaining active lane. Masked lanes cost zero cycles.
  - On transfer, clear that lane's remaining bit and increment issued.
  - Without ready, ev_start and ev_x stay stable.
  - After the last transfer: ev_start=0 on the next edge; go to DRAIN, or straight to DONE if returned==issued.
- ev_done (ISSUE or DRAIN):
  - acc += sign-extended ev_y, using an ACC_WIDTH+1-bit sum.
  - On overflow, clamp to max positive or max negative and set overflow (sticky until CLEAR or rst).
  - Increment returned.
  - ev_done in IDLE/DONE is a protocol violation: ignored; the bench asserts it never happens.
- DRAIN: wait until returned==issued, then go to DONE. For GO_READ, result=saturated acc on that same edge. For GO, result is unchanged.
- Simultaneous last transfer and ev_done in ISSUE: both are counted. The exit test uses the updated counts.
- start outside IDLE is ignored.

Decomposition:
- Shared package multi_lane_sum_pkg holds:
  - opcode constants OP_CLEAR/OP_GO/OP_READ/OP_GO_READ;
  - state encodings;
  - saturation max/min helper function.
- Sub-module lane_select: combinational lowest-set-bit priority encoder over the remaining mask, outputting index and any_left.

Test Plan:
- Reset, then CLEAR at T -> done=1 only at T+1, overflow=0; READ -> result=0, busy high exactly one cycle.
- Bench evaluator (y=x[21:0], latency 3, ready=1); GO_READ, mask=3'b111, x={30,20,10} -> ev_x 10,20,30 on three consecutive cycles; done after third ev_done; result=60.
- GO_READ, mask=3'b101, x={7,99,5} -> only 5 and 7 issued, two ev_start cycles; result=72 (60+12); GO alone leaves result unchanged until READ.
- ev_ready low 4 cycles mid-ISSUE, plus clk_en low 2 cycles -> ev_start/ev_x stable, no lane lost or duplicated, final sum correct.
- ACC_WIDTH=22: three results of 22'h1FFFFF -> result=22'h1FFFFF, overflow=1; CLEAR -> overflow=0, acc=0; negative case clamps to 22'h200000.
- rst asserted in DRAIN -> outputs zero immediately; next GO with mask=0 -> done at T+1, acc unchanged (0).
